// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline-stage register: DEPTH-entry valid/ready FIFO with synchronous flush.
// Control and payload read as zero whenever no entry is held, so bubbles never assert writes.
module pipe_stage_fifo #(
    parameter int DATA_BITS = 32,
    parameter int CTRL_BITS = 4,
    parameter int DEPTH     = 2,
    localparam int CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic [CTRL_BITS-1:0] i_ctrl,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic [CTRL_BITS-1:0] o_ctrl,
    output logic [CNT_BITS-1:0]  o_count
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int ENTRY_BITS = DATA_BITS + CTRL_BITS;
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

    logic [ENTRY_BITS-1:0] mem [DEPTH];
    logic [ENTRY_BITS-1:0] head;
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [CNT_BITS-1:0]   count;
    logic                  push;
    logic                  pop;

    // o_ready depends only on registered occupancy, never on i_ready.
    always_comb begin
        o_ready = (count != FULL_CNT);
        o_valid = (count != '0);
        push    = i_valid & o_ready & ~i_flush;
        pop     = o_valid & i_ready & ~i_flush;
        head    = mem[rd_ptr];
        o_data  = o_valid ? head[DATA_BITS-1:0] : '0;
        o_ctrl  = o_valid ? head[ENTRY_BITS-1:DATA_BITS] : '0;
        o_count = count;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_ctrl, i_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_BITS'(1);
            end else if (pop && !push) begin
                count <= count - CNT_BITS'(1);
            end
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);
    a_valid_count: assert property (@(posedge clk) disable iff (rst) o_valid |-> (o_count != '0));
    a_bubble_ctrl: assert property (@(posedge clk) disable iff (rst) !o_valid |-> (o_ctrl == '0));

endmodule
